// File: rtl/fwd_reg_slice_if.sv
// ---------------------------------------------------------------------------
// fwd_reg_slice_if
//   One valid/ready channel that carries a W-bit payload.
//
//   Handshake rule: a beat transfers on a rising clock edge when valid and
//   ready are both 1. While valid is 1 and ready is 0, the master keeps
//   valid and payload stable. The fwd_reg_slice input side does not rely
//   on this: its producer may withdraw valid without a transfer.
//
//   Signals
//     valid    master -> slave  a beat is present on payload
//     payload  master -> slave  W-bit data
//     ready    slave  -> master the slave accepts the beat this cycle
//
//   Modports
//     master   drives valid and payload, samples ready
//     slave    samples valid and payload, drives ready
// ---------------------------------------------------------------------------
interface fwd_reg_slice_if #(
  parameter int W = 32
);
  logic         valid;
  logic [W-1:0] payload;
  logic         ready;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/fwd_reg_slice.sv
// ---------------------------------------------------------------------------
// dff
//   A bank of W D flip-flops. The load enable and the asynchronous
//   active-low reset can each be included or left out.
//     EN=1   q loads d on a rising edge only when en=1
//     EN=0   q loads d on every rising edge, and en is ignored
//     RST=1  rst_n low forces q to RST_V at once
//     RST=0  the bank has no reset, and rst_n is ignored
//   Ports: clk, rst_n, en, d[W], q[W]
// ---------------------------------------------------------------------------
module dff #(
  parameter int           W     = 1,
  parameter bit           RST   = 1'b1,
  parameter bit           EN    = 1'b1,
  parameter logic [W-1:0] RST_V = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic load;
  assign load = en | ~EN;

  if (RST) begin : g_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= RST_V;
      else if (load) q <= d;
    end
  end else begin : g_no_rst
    // This bank has no reset, so rst_n has no load here.
    logic unused_rst_n;
    assign unused_rst_n = rst_n;

    always_ff @(posedge clk) begin
      if (load) q <= d;
    end
  end
endmodule

// ---------------------------------------------------------------------------
// fwd_reg_slice
//   A single-entry pipeline slice with a registered forward path. It breaks
//   the valid and payload timing path between a producer and a consumer.
//   output_valid and output_payload come straight from flops. The only
//   combinational path is input_ready = ~valid_q | output_ready.
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     in_if   slave side: input_valid, input_payload, input_ready
//     out_if  master side: output_valid, output_payload, output_ready
//
//   Parameters
//     W      payload width
//     RST    1: payload register resets to RST_V; 0: payload has no reset
//     RST_V  payload reset value
// ---------------------------------------------------------------------------
module fwd_reg_slice #(
  parameter int           W     = 32,
  parameter bit           RST   = 1'b1,
  parameter logic [W-1:0] RST_V = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  fwd_reg_slice_if.slave    in_if,
  fwd_reg_slice_if.master   out_if
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         data_en;
  logic         in_fire, out_fire;

  // The slice can accept a beat when it is empty, or when it is full and
  // the held beat leaves on the same edge.
  assign in_if.ready = ~valid_q | out_if.ready;

  always_comb begin
    in_fire  = in_if.valid & in_if.ready;
    out_fire = valid_q & out_if.ready;
    valid_d  = valid_q;
    data_d   = in_if.payload;
    data_en  = in_fire;
    // A push wins over a pop. When the slice is full and draining, the new
    // beat replaces the old one and valid stays high.
    if (in_fire)       valid_d = 1'b1;
    else if (out_fire) valid_d = 1'b0;
  end

  // The valid flop is always reset and loads on every edge.
  dff #(.W(1), .RST(1'b1), .EN(1'b0), .RST_V(1'b0)) u_valid_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (valid_d),
    .q     (valid_q)
  );

  // The payload changes only on an accepted beat. After a pop it keeps its
  // last value, and nothing clears it.
  dff #(.W(W), .RST(RST), .EN(1'b1), .RST_V(RST_V)) u_data_dff (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (data_en),
    .d     (data_d),
    .q     (data_q)
  );

  assign out_if.valid   = valid_q;
  assign out_if.payload = data_q;
endmodule

// File: tb/tb_fwd_reg_slice.sv
// ---------------------------------------------------------------------------
// tb_fwd_reg_slice
//   dut_a: W=8, RST=1, RST_V=8'hA5. Runs the directed scenarios.
//   dut_b: W=32, RST=0. Runs the random valid/ready stream, which is
//   checked against a queue model of the single slot.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled
//   4 time units after the rising edge, well before the next one.
// ---------------------------------------------------------------------------
module tb_fwd_reg_slice;
  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  always #5 clk = ~clk;

  fwd_reg_slice_if #(.W(8))  a_in ();
  fwd_reg_slice_if #(.W(8))  a_out ();
  fwd_reg_slice_if #(.W(32)) b_in ();
  fwd_reg_slice_if #(.W(32)) b_out ();

  fwd_reg_slice #(.W(8), .RST(1'b1), .RST_V(8'hA5)) dut_a (
    .clk    (clk),
    .rst_n  (rst_n_a),
    .in_if  (a_in),
    .out_if (a_out)
  );

  fwd_reg_slice #(.W(32), .RST(1'b0), .RST_V(32'h0)) dut_b (
    .clk    (clk),
    .rst_n  (rst_n_b),
    .in_if  (b_in),
    .out_if (b_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] p, input logic r);
    a_in.valid   = v;
    a_in.payload = p;
    a_out.ready  = r;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_a(1'b0, 8'h00, 1'b0);
    next_cycle();
    next_cycle();
    rst_n_a = 1'b1;
    next_cycle();
    // Load a beat so that the reset has state to clear.
    drive_a(1'b1, 8'h5A, 1'b0);
    next_cycle();
    drive_a(1'b0, 8'h00, 1'b0);
    #3;
    n_vec++;
    if (a_out.valid !== 1'b1) begin
      n_err++; $display("FAIL reset_preload_valid: got %b expected 1", a_out.valid);
    end
    // Assert reset between clock edges, then sample before any edge.
    rst_n_a = 1'b0;
    #1;
    n_vec++;
    if (a_out.valid !== 1'b0) begin
      n_err++; $display("FAIL reset_async_valid: got %b expected 0", a_out.valid);
    end
    n_vec++;
    if (a_out.payload !== 8'hA5) begin
      n_err++; $display("FAIL reset_async_payload: got %h expected a5", a_out.payload);
    end
    n_vec++;
    if (a_in.ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", a_in.ready);
    end
    next_cycle();
    rst_n_a = 1'b1;
    next_cycle();
  endtask

  task automatic test_streaming();
    logic [7:0] vals [3];
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive_a(1'b1, vals[i], 1'b1);
      else       drive_a(1'b0, 8'h00, 1'b1);
      #3;
      n_vec++;
      if (a_in.ready !== 1'b1) begin
        n_err++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, a_in.ready);
      end
      if (i > 0) begin
        n_vec++;
        if (a_out.valid !== 1'b1 || a_out.payload !== vals[i-1]) begin
          n_err++;
          $display("FAIL stream_out[%0d]: got v=%b p=%h expected v=1 p=%h",
                   i, a_out.valid, a_out.payload, vals[i-1]);
        end
      end
      next_cycle();
    end
    #3;
    n_vec++;
    if (a_out.valid !== 1'b0) begin
      n_err++; $display("FAIL stream_empty_after: got %b expected 0", a_out.valid);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    drive_a(1'b1, 8'h11, 1'b0);
    next_cycle();
    drive_a(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3;
      n_vec++;
      if (a_out.valid !== 1'b1 || a_out.payload !== 8'h11 || a_in.ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got v=%b p=%h rdy=%b expected v=1 p=11 rdy=0",
                 i, a_out.valid, a_out.payload, a_in.ready);
      end
      next_cycle();
    end
    a_out.ready = 1'b1;
    #3;
    n_vec++;
    if (a_in.ready !== 1'b1 || a_out.payload !== 8'h11) begin
      n_err++;
      $display("FAIL bp_release: got rdy=%b p=%h expected rdy=1 p=11", a_in.ready, a_out.payload);
    end
    next_cycle();
    drive_a(1'b0, 8'h00, 1'b0);
    #3;
    n_vec++;
    if (a_out.valid !== 1'b1 || a_out.payload !== 8'h22) begin
      n_err++;
      $display("FAIL bp_replace: got v=%b p=%h expected v=1 p=22", a_out.valid, a_out.payload);
    end
    // Pop 8'h22 so that the next scenario starts from an empty slice.
    a_out.ready = 1'b1;
    next_cycle();
  endtask

  task automatic test_drain();
    drive_a(1'b1, 8'h33, 1'b0);
    next_cycle();
    drive_a(1'b0, 8'h00, 1'b1);
    #3;
    n_vec++;
    if (a_out.valid !== 1'b1 || a_out.payload !== 8'h33) begin
      n_err++;
      $display("FAIL drain_full: got v=%b p=%h expected v=1 p=33", a_out.valid, a_out.payload);
    end
    next_cycle();
    #3;
    n_vec++;
    if (a_out.valid !== 1'b0 || a_out.payload !== 8'h33) begin
      n_err++;
      $display("FAIL drain_empty: got v=%b p=%h expected v=0 p=33", a_out.valid, a_out.payload);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    drive_a(1'b1, 8'h44, 1'b0);
    next_cycle();
    drive_a(1'b0, 8'h00, 1'b0);
    #2;
    rst_n_a = 1'b0;
    #1;
    n_vec++;
    if (a_out.valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_valid: got %b expected 0", a_out.valid);
    end
    next_cycle();
    rst_n_a = 1'b1;
    next_cycle();
    #3;
    n_vec++;
    if (a_out.valid !== 1'b0 || a_out.payload !== 8'hA5 || a_in.ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_after: got v=%b p=%h rdy=%b expected v=0 p=a5 rdy=1",
               a_out.valid, a_out.payload, a_in.ready);
    end
    next_cycle();
  endtask

  // Random stream on dut_b. The model is a queue that holds at most one
  // beat. Its front is what the slice must be presenting.
  task automatic test_random();
    logic [31:0] exp_q[$];
    logic        exp_valid, exp_in_ready, in_fire, out_fire;
    logic        prev_stall;
    logic [31:0] prev_payload;
    int          n_push;
    int          n_pop;
    n_push = 0;
    n_pop  = 0;
    prev_stall = 1'b0;
    prev_payload = '0;
    b_in.valid = 1'b0; b_in.payload = '0; b_out.ready = 1'b0;
    next_cycle();
    rst_n_b = 1'b1;
    next_cycle();
    for (int cyc = 0; cyc < 10010; cyc++) begin
      if (cyc < 10000) begin
        b_in.valid   = ($urandom_range(0, 99) < 60);
        b_in.payload = $urandom;
        b_out.ready  = ($urandom_range(0, 99) < 55);
      end else begin
        b_in.valid  = 1'b0;
        b_out.ready = 1'b1;
      end
      #3;
      exp_valid    = (exp_q.size() != 0);
      exp_in_ready = !exp_valid || b_out.ready;
      n_vec++;
      if (b_out.valid !== exp_valid || b_in.ready !== exp_in_ready) begin
        n_err++;
        $display("FAIL rand_ctrl[%0d]: got v=%b rdy=%b expected v=%b rdy=%b",
                 cyc, b_out.valid, b_in.ready, exp_valid, exp_in_ready);
      end
      if (exp_valid) begin
        n_vec++;
        if (b_out.payload !== exp_q[0]) begin
          n_err++;
          $display("FAIL rand_data[%0d]: got %h expected %h", cyc, b_out.payload, exp_q[0]);
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (b_out.payload !== prev_payload) begin
          n_err++;
          $display("FAIL rand_stable[%0d]: got %h expected %h", cyc, b_out.payload, prev_payload);
        end
      end
      in_fire  = b_in.valid && exp_in_ready;
      out_fire = exp_valid && b_out.ready;
      prev_stall = exp_valid && !b_out.ready;
      prev_payload = exp_valid ? exp_q[0] : '0;
      if (out_fire) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (in_fire) begin
        exp_q.push_back(b_in.payload);
        n_push++;
      end
      next_cycle();
    end
    n_vec++;
    if (exp_q.size() != 0 || n_push != n_pop || b_out.valid !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain: got left=%0d push=%0d pop=%0d v=%b expected left=0 push=pop v=0",
               exp_q.size(), n_push, n_pop, b_out.valid);
    end
  endtask

  initial begin
    drive_a(1'b0, 8'h00, 1'b0);
    b_in.valid = 1'b0; b_in.payload = '0; b_out.ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
